// File: rtl/hangman_pkg.sv
// Shared types and constants for the hangman game: FSM state codes, letter codes
// and the fixed word table indexed by level.
package hangman_pkg;

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StLoad = 3'd1,
      StPlay = 3'd2,
      StDead = 3'd3,
      StWon  = 3'd4
   } state_e;

   localparam int unsigned TBL_LETTER_W = 5;
   localparam int unsigned TBL_WORD_LEN = 6;
   localparam int unsigned TBL_WORD_W   = TBL_LETTER_W * TBL_WORD_LEN;
   localparam int unsigned TABLE_DEPTH  = 8;
   localparam int unsigned TABLE_IDX_W  = 3;

   typedef logic [TBL_LETTER_W-1:0] letter_t;
   typedef logic [TBL_WORD_W-1:0]   word_t;

   localparam letter_t LETTER_BLANK = 5'd0;
   localparam letter_t LETTER_A = 5'd1;
   localparam letter_t LETTER_B = 5'd2;
   localparam letter_t LETTER_C = 5'd3;
   localparam letter_t LETTER_D = 5'd4;
   localparam letter_t LETTER_E = 5'd5;
   localparam letter_t LETTER_F = 5'd6;
   localparam letter_t LETTER_G = 5'd7;
   localparam letter_t LETTER_H = 5'd8;
   localparam letter_t LETTER_I = 5'd9;
   localparam letter_t LETTER_J = 5'd10;
   localparam letter_t LETTER_K = 5'd11;
   localparam letter_t LETTER_L = 5'd12;
   localparam letter_t LETTER_M = 5'd13;
   localparam letter_t LETTER_N = 5'd14;
   localparam letter_t LETTER_O = 5'd15;
   localparam letter_t LETTER_P = 5'd16;
   localparam letter_t LETTER_Q = 5'd17;
   localparam letter_t LETTER_R = 5'd18;
   localparam letter_t LETTER_S = 5'd19;
   localparam letter_t LETTER_T = 5'd20;
   localparam letter_t LETTER_U = 5'd21;
   localparam letter_t LETTER_V = 5'd22;
   localparam letter_t LETTER_W = 5'd23;
   localparam letter_t LETTER_X = 5'd24;
   localparam letter_t LETTER_Y = 5'd25;
   localparam letter_t LETTER_Z = 5'd26;

   // Letter 0 sits in the MSBs; short words are right-padded with blanks.
   localparam word_t WORD_TABLE [TABLE_DEPTH] = '{
      {LETTER_P, LETTER_L, LETTER_A, LETTER_N, LETTER_E, LETTER_T},
      {LETTER_C, LETTER_A, LETTER_S, LETTER_T, LETTER_L, LETTER_E},
      {LETTER_G, LETTER_A, LETTER_R, LETTER_D, LETTER_E, LETTER_N},
      {LETTER_B, LETTER_R, LETTER_I, LETTER_D, LETTER_G, LETTER_E},
      {LETTER_Q, LETTER_U, LETTER_I, LETTER_Z, LETTER_BLANK, LETTER_BLANK},
      {LETTER_S, LETTER_P, LETTER_H, LETTER_I, LETTER_N, LETTER_X},
      {LETTER_O, LETTER_X, LETTER_Y, LETTER_G, LETTER_E, LETTER_N},
      {LETTER_Z, LETTER_E, LETTER_B, LETTER_R, LETTER_A, LETTER_S}
   };

endpackage

// File: rtl/mask_builder.sv
// Serial alphabet-presence scanner: after a clear strobe it visits one letter of
// the word per cycle, setting the mask bit for each valid letter code.
module mask_builder
   import hangman_pkg::*;
#(
   parameter int unsigned WORD_LEN = 6,
   parameter int unsigned LETTER_W = 5,
   parameter int unsigned ALPHA    = 26
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         clear_i,
   input  logic [WORD_LEN*LETTER_W-1:0] word_i,
   output logic [ALPHA-1:0]             mask_o,
   output logic                         busy_o,
   output logic                         done_o
);

   localparam int unsigned IDX_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;

   logic [ALPHA-1:0]             mask_q, mask_d;
   logic [IDX_W-1:0]             idx_q, idx_d;
   logic                         busy_q, busy_d;
   logic [WORD_LEN*LETTER_W-1:0] shifted;
   logic [LETTER_W-1:0]          code;
   int unsigned                  shift_amt;

   always_comb begin
      shift_amt = LETTER_W * (WORD_LEN - 1 - int'(idx_q));
      shifted   = word_i >> shift_amt;
      code      = shifted[LETTER_W-1:0];
   end

   // High on the cycle that scans the final letter.
   assign done_o = busy_q && (idx_q == IDX_W'(WORD_LEN - 1));
   assign busy_o = busy_q;
   assign mask_o = mask_q;

   always_comb begin
      mask_d = mask_q;
      idx_d  = idx_q;
      busy_d = busy_q;
      if (clear_i) begin
         mask_d = '0;
         idx_d  = '0;
         busy_d = 1'b1;
      end else if (busy_q) begin
         // Blank and out-of-range codes match no bit.
         for (int c = 0; c < int'(ALPHA); c++) begin
            if (code == LETTER_W'(c + 1)) begin
               mask_d[c] = 1'b1;
            end
         end
         if (done_o) begin
            busy_d = 1'b0;
            idx_d  = '0;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mask_q <= '0;
         idx_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         mask_q <= mask_d;
         idx_q  <= idx_d;
         busy_q <= busy_d;
      end
   end

endmodule

// File: rtl/level_sequencer.sv
// Hangman level controller: walks the word table on win/lose events and presents
// the current word with its serially built alphabet-presence mask.
module level_sequencer
   import hangman_pkg::*;
#(
   parameter int unsigned NUM_LEVELS = 4,
   parameter int unsigned WORD_LEN   = 6,
   parameter int unsigned LETTER_W   = 5,
   parameter int unsigned ALPHA      = 26,
   parameter int unsigned LEVEL_W    = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start_game,
   input  logic                         level_won,
   input  logic                         lost_game,
   output logic [WORD_LEN*LETTER_W-1:0] word,
   output logic [ALPHA-1:0]             mask,
   output logic                         word_valid,
   output logic [LEVEL_W-1:0]           level,
   output logic [2:0]                   current_state,
   output logic                         game_won
);

   localparam int unsigned WORD_W = WORD_LEN * LETTER_W;

   state_e              state_q, state_d;
   logic [LEVEL_W-1:0]  level_q, level_d;
   logic [WORD_W-1:0]   word_q, word_d;
   logic                word_valid_q, word_valid_d;
   logic                game_won_q, game_won_d;
   logic                mb_clear, mb_busy, mb_done;
   logic [TABLE_IDX_W-1:0] tbl_idx;

   assign tbl_idx = TABLE_IDX_W'(level_q);

   // First LOAD cycle (scanner idle) latches the word and restarts the scan.
   assign mb_clear = (state_q == StLoad) && !mb_busy;

   mask_builder #(
      .WORD_LEN (WORD_LEN),
      .LETTER_W (LETTER_W),
      .ALPHA    (ALPHA)
   ) u_mask_builder (
      .clk     (clk),
      .reset   (reset),
      .clear_i (mb_clear),
      .word_i  (word_q),
      .mask_o  (mask),
      .busy_o  (mb_busy),
      .done_o  (mb_done)
   );

   always_comb begin
      state_d = state_q;
      level_d = level_q;
      word_d  = word_q;
      unique case (state_q)
         StIdle: begin
            if (start_game) begin
               state_d = StLoad;
               level_d = '0;
            end
         end
         StLoad: begin
            if (mb_clear) begin
               word_d = WORD_W'(WORD_TABLE[tbl_idx]);
            end else if (mb_done) begin
               state_d = StPlay;
            end
         end
         StPlay: begin
            if (lost_game) begin
               state_d = StDead;
            end else if (level_won) begin
               if (level_q == LEVEL_W'(NUM_LEVELS - 1)) begin
                  state_d = StWon;
               end else begin
                  state_d = StLoad;
                  level_d = level_q + 1'b1;
               end
            end
         end
         StDead, StWon: begin
            if (start_game) begin
               state_d = StLoad;
               level_d = '0;
            end
         end
         default: state_d = StIdle;
      endcase
      word_valid_d = (state_d == StPlay);
      game_won_d   = (state_d == StWon);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         level_q      <= '0;
         word_q       <= '0;
         word_valid_q <= 1'b0;
         game_won_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         level_q      <= level_d;
         word_q       <= word_d;
         word_valid_q <= word_valid_d;
         game_won_q   <= game_won_d;
      end
   end

   assign word          = word_q;
   assign level         = level_q;
   assign word_valid    = word_valid_q;
   assign current_state = state_q;
   assign game_won      = game_won_q;

endmodule

// File: tb/tb_level_sequencer.sv
// Directed self-checking bench for level_sequencer.
module tb_level_sequencer;

   localparam logic [29:0] W_PLANET = {5'd16, 5'd12, 5'd1, 5'd14, 5'd5, 5'd20};
   localparam logic [29:0] W_CASTLE = {5'd3, 5'd1, 5'd19, 5'd20, 5'd12, 5'd5};
   localparam logic [29:0] W_BRIDGE = {5'd2, 5'd18, 5'd9, 5'd4, 5'd7, 5'd5};
   localparam logic [25:0] M_PLANET = 26'h008A811;
   localparam logic [25:0] M_CASTLE = 26'h00C0815;
   localparam logic [25:0] M_BRIDGE = 26'h002015A;
   localparam logic [2:0]  S_IDLE = 3'd0, S_LOAD = 3'd1, S_PLAY = 3'd2;
   localparam logic [2:0]  S_DEAD = 3'd3, S_WON = 3'd4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start_game = 1'b0;
   logic        level_won = 1'b0;
   logic        lost_game = 1'b0;
   logic [29:0] word;
   logic [25:0] mask;
   logic        word_valid;
   logic [1:0]  level;
   logic [2:0]  current_state;
   logic        game_won;

   int n_cmp = 0;
   int n_bad = 0;

   level_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .start_game    (start_game),
      .level_won     (level_won),
      .lost_game     (lost_game),
      .word          (word),
      .mask          (mask),
      .word_valid    (word_valid),
      .level         (level),
      .current_state (current_state),
      .game_won      (game_won)
   );

   always #5 clk = ~clk;

   task automatic pulse(input logic s, input logic w, input logic l);
      @(negedge clk);
      start_game = s;
      level_won  = w;
      lost_game  = l;
      @(posedge clk);
      #1;
      start_game = 1'b0;
      level_won  = 1'b0;
      lost_game  = 1'b0;
   endtask

   // Edges after the launching edge until word_valid rises (20 means timed out).
   task automatic wait_valid(output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!word_valid && n < 20);
   endtask

   task automatic test_reset;
      #3;
      n_cmp++; if (current_state !== S_IDLE) begin n_bad++;
         $display("FAIL reset_state got %0d want %0d", current_state, S_IDLE); end
      n_cmp++; if ({word, mask, level, word_valid, game_won} !== '0) begin n_bad++;
         $display("FAIL reset_outputs got %h/%h/%0d/%b/%b want all zero",
                  word, mask, level, word_valid, game_won); end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      pulse(1'b0, 1'b1, 1'b1);
      n_cmp++; if (current_state !== S_IDLE || level !== 2'd0) begin n_bad++;
         $display("FAIL idle_ignore got state %0d level %0d want 0 0", current_state, level); end
   endtask

   task automatic test_start;
      int n;
      pulse(1'b1, 1'b0, 1'b0);
      n_cmp++; if (current_state !== S_LOAD) begin n_bad++;
         $display("FAIL start_to_load got %0d want %0d", current_state, S_LOAD); end
      wait_valid(n);
      n_cmp++; if (n !== 7) begin n_bad++;
         $display("FAIL start_latency got %0d want 7", n); end
      n_cmp++; if (word !== W_PLANET || mask !== M_PLANET || level !== 2'd0) begin n_bad++;
         $display("FAIL start_word got %h/%h/%0d want %h/%h/0", word, mask, level,
                  W_PLANET, M_PLANET); end
      n_cmp++; if (current_state !== S_PLAY) begin n_bad++;
         $display("FAIL start_play got %0d want %0d", current_state, S_PLAY); end
   endtask

   task automatic test_level_up;
      int n;
      pulse(1'b0, 1'b1, 1'b0);
      n_cmp++; if (word_valid !== 1'b0 || current_state !== S_LOAD) begin n_bad++;
         $display("FAIL levelup_drop got valid %b state %0d want 0 %0d", word_valid,
                  current_state, S_LOAD); end
      wait_valid(n);
      n_cmp++; if (n !== 7) begin n_bad++;
         $display("FAIL levelup_latency got %0d want 7", n); end
      n_cmp++; if (word !== W_CASTLE || mask !== M_CASTLE || level !== 2'd1) begin n_bad++;
         $display("FAIL levelup_word got %h/%h/%0d want %h/%h/1", word, mask, level,
                  W_CASTLE, M_CASTLE); end
   endtask

   task automatic test_simultaneous;
      int n;
      pulse(1'b0, 1'b1, 1'b1);
      n_cmp++; if (current_state !== S_DEAD || game_won !== 1'b0 || word_valid !== 1'b0)
         begin n_bad++;
         $display("FAIL simul_dead got state %0d won %b valid %b want %0d 0 0",
                  current_state, game_won, word_valid, S_DEAD); end
      n_cmp++; if (level !== 2'd1 || word !== W_CASTLE || mask !== M_CASTLE) begin n_bad++;
         $display("FAIL simul_hold got %0d/%h/%h want 1/%h/%h", level, word, mask,
                  W_CASTLE, M_CASTLE); end
      pulse(1'b0, 1'b1, 1'b1);
      n_cmp++; if (current_state !== S_DEAD || level !== 2'd1) begin n_bad++;
         $display("FAIL dead_ignore got state %0d level %0d want %0d 1", current_state,
                  level, S_DEAD); end
      pulse(1'b1, 1'b0, 1'b0);
      n_cmp++; if (current_state !== S_LOAD || level !== 2'd0) begin n_bad++;
         $display("FAIL dead_restart got state %0d level %0d want %0d 0", current_state,
                  level, S_LOAD); end
      wait_valid(n);
      n_cmp++; if (n !== 7 || word !== W_PLANET || mask !== M_PLANET) begin n_bad++;
         $display("FAIL dead_reload got %0d/%h/%h want 7/%h/%h", n, word, mask,
                  W_PLANET, M_PLANET); end
   endtask

   task automatic test_win;
      int n;
      for (int i = 1; i <= 3; i++) begin
         pulse(1'b0, 1'b1, 1'b0);
         wait_valid(n);
         n_cmp++; if (n !== 7 || level !== 2'(i)) begin n_bad++;
            $display("FAIL win_climb got latency %0d level %0d want 7 %0d", n, level, i); end
      end
      n_cmp++; if (word !== W_BRIDGE || mask !== M_BRIDGE) begin n_bad++;
         $display("FAIL win_word3 got %h/%h want %h/%h", word, mask, W_BRIDGE, M_BRIDGE); end
      pulse(1'b1, 1'b0, 1'b0);
      n_cmp++; if (current_state !== S_PLAY || word_valid !== 1'b1) begin n_bad++;
         $display("FAIL play_start_ignore got state %0d valid %b want %0d 1", current_state,
                  word_valid, S_PLAY); end
      pulse(1'b0, 1'b1, 1'b0);
      n_cmp++; if (current_state !== S_WON || game_won !== 1'b1 || level !== 2'd3 ||
                   word_valid !== 1'b0) begin n_bad++;
         $display("FAIL win_enter got state %0d won %b level %0d valid %b want %0d 1 3 0",
                  current_state, game_won, level, word_valid, S_WON); end
      pulse(1'b0, 1'b1, 1'b0);
      pulse(1'b0, 1'b0, 1'b1);
      n_cmp++; if (current_state !== S_WON || level !== 2'd3 || word !== W_BRIDGE ||
                   mask !== M_BRIDGE) begin n_bad++;
         $display("FAIL won_ignore got state %0d level %0d word %h mask %h", current_state,
                  level, word, mask); end
   endtask

   task automatic test_load_ignore;
      int n = 0;
      pulse(1'b1, 1'b0, 1'b0);
      do begin
         @(negedge clk);
         if (n < 6) begin
            start_game = (n % 3) == 0;
            level_won  = (n % 3) == 1;
            lost_game  = (n % 3) == 2;
         end
         @(posedge clk);
         #1;
         start_game = 1'b0;
         level_won  = 1'b0;
         lost_game  = 1'b0;
         n++;
      end while (!word_valid && n < 20);
      n_cmp++; if (n !== 7 || level !== 2'd0 || word !== W_PLANET || mask !== M_PLANET)
         begin n_bad++;
         $display("FAIL load_ignore got %0d/%0d/%h/%h want 7/0/%h/%h", n, level, word, mask,
                  W_PLANET, M_PLANET); end
      n_cmp++; if (current_state !== S_PLAY || game_won !== 1'b0) begin n_bad++;
         $display("FAIL load_ignore_state got %0d won %b want %0d 0", current_state,
                  game_won, S_PLAY); end
   endtask

   task automatic test_reset_mid_load;
      int n;
      pulse(1'b0, 1'b1, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      level_won = 1'b1;
      lost_game = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      n_cmp++; if (current_state !== S_IDLE || {word, mask, level, word_valid, game_won} !== '0)
         begin n_bad++;
         $display("FAIL midload_reset got state %0d word %h mask %h level %0d valid %b",
                  current_state, word, mask, level, word_valid); end
      level_won = 1'b0;
      lost_game = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      pulse(1'b1, 1'b0, 1'b0);
      wait_valid(n);
      n_cmp++; if (n !== 7 || word !== W_PLANET || mask !== M_PLANET || level !== 2'd0)
         begin n_bad++;
         $display("FAIL midload_restart got %0d/%h/%h/%0d want 7/%h/%h/0", n, word, mask,
                  level, W_PLANET, M_PLANET); end
   endtask

   initial begin
      test_reset();
      test_start();
      test_level_up();
      test_simultaneous();
      test_win();
      test_load_ignore();
      test_reset_mid_load();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
